sdram_row_controller: RTL and testbench
=======================================

// Module: sdram_row_controller
// PURPOSE
//   Initiator for one sdram_bank. Turns single-word CPU accesses into whole-row
//   bank transfers and keeps one open row in a row buffer.
//   - Fetches a 512x32 row, extracts or merges the 32-bit word, and writes dirty
//     rows back.
//   - Stalls while the bank signals refresh (wait).
//   - Sits between the MIPS memory arbiter and the SDRAM bank.
// PARAMETERS
//   ROW_WORDS   512  32-bit words per bank row
//   WORD_IDX_W  9    log2(ROW_WORDS); word index = cpu_address[WORD_IDX_W-1:0]
//   ROW_ADDR_W  13   bank row (column_address) bits; row = cpu_address[WORD_IDX_W+:ROW_ADDR_W]
// PORTS
//   clock              in   1                  system clock, all logic on posedge
//   reset              in   1                  synchronous, active-high
//   cpu_read           in   1                  read request, held until cpu_ack
//   cpu_write          in   1                  write request, held until cpu_ack
//   cpu_address        in   ROW_ADDR_W+WORD_IDX_W  word address
//   cpu_writedata      in   32                 write data
//   cpu_readdata       out  32                 read data, valid with cpu_ack, held until next ack
//   cpu_ack            out  1                  one-cycle completion pulse
//   bank_wait          in   1                  bank refresh busy (sdram_bank wait_signal)
//   bank_write_enable  out  1                  1 = write row to bank, 0 = read
//   bank_column_addr   out  ROW_ADDR_W         bank row select
//   bank_row_wdata     out  ROW_WORDS*32       row driven to bank (top level tristates onto row bus when bank_write_enable=1)
//   bank_row_rdata     in   ROW_WORDS*32       row returned by bank (registered in bank, 1-cycle latency)
// BEHAVIOUR
//   Reset values (all registered):
//     - Outputs: cpu_ack=0, cpu_readdata=0, bank_write_enable=0,
//       bank_column_addr=0, bank_row_wdata=0.
//     - Internal: state=IDLE, buf_valid=0, buf_dirty=0.
//   States and transitions:
//     - IDLE: sample request at posedge. cpu_write has priority if both are high.
//       No request is accepted in the cycle cpu_ack=1.
//     - FETCH: bank_write_enable=0, bank_column_addr=target row, held stable.
//       Leave on the first posedge with bank_wait=0, then go to CAPTURE.
//     - CAPTURE: load row buffer from bank_row_rdata; buf_valid=1, tag=row.
//       Read: cpu_readdata<=word. Write: merge word, set dirty.
//       Then ack (or WRITEBACK when not cached, see CONFIGURATION).
//     - WRITEBACK: bank_write_enable=1, bank_column_addr=buffer tag,
//       bank_row_wdata=buffer. Completes on the first posedge with bank_wait=0;
//       bank_write_enable=0 in the next cycle; buf_dirty=0.
//       Continues to FETCH (eviction) or acks (write-through).
//   Timing:
//     - cpu_ack is asserted the cycle after completion and lasts exactly 1 cycle.
//     - Latency with bank_wait=0, counted from accepting edge to the ack cycle:
//       hit 1, clean miss 3, dirty miss 4.
//     - Each cycle of bank_wait=1 in FETCH or WRITEBACK adds exactly 1 cycle.
//   Boundary cases:
//     - Request deasserted mid-operation: the operation still completes and
//       cpu_ack still pulses.
//     - Address changed mid-operation: ignored. Address and data are latched at
//       acceptance.
//     - Reset in any state: next cycle state=IDLE, bank_write_enable=0,
//       buf_valid=0. Dirty data is discarded.
//     - Word index ROW_WORDS-1 and row 2^ROW_ADDR_W-1 need no wrap handling.
//       Address bits above the used width are ignored.
// CONFIGURATION
//   SDRAM_ROW_CACHE_EN defined:
//     - The buffer persists across accesses.
//     - Hit = buf_valid && tag==row. Read hit returns the word; write hit merges
//       and sets dirty. Both ack after 1 cycle with no bank traffic.
//     - Miss: WRITEBACK if dirty, then FETCH, CAPTURE.
//   SDRAM_ROW_CACHE_EN undefined:
//     - No hits; buf_valid is cleared after each ack.
//     - Read: FETCH, CAPTURE, ack (3 cycles).
//     - Write: FETCH, CAPTURE (merge), WRITEBACK, ack (4 cycles).
//       The bank is always current after ack.
// TESTING
//   1 Hold reset 2 cycles with requests high -> all outputs 0, no cpu_ack, bank_write_enable=0.
//   2 Preload bank row 5 word 3=0xDEADBEEF; read address (5<<9)|3 -> cpu_ack in 3rd cycle, cpu_readdata=0xDEADBEEF.
//   3 Write 0x12345678 to (5<<9)|3, then read it -> with _EN: both ack after 1 cycle, data 0x12345678,
//     bank row 5 unchanged; without _EN: write acks in 4 cycles, bank row 5 word 3=0x12345678.
//   4 (_EN) After test 3, read (6<<9)|0 -> WRITEBACK of row 5 first (bank word 3=0x12345678),
//     then fetch row 6, ack in 4th cycle.
//   5 Raise bank_wait for 66 cycles while in FETCH -> bank_column_addr held stable,
//     ack delayed by exactly 66 cycles, data correct.
//   6 Assert reset while in WRITEBACK -> bank_write_enable=0 next cycle, state IDLE;
//     next read of the same row misses (3 cycles).

Source files
------------

// File: rtl/sdram_row_controller.sv
// Row-buffer initiator for one sdram_bank: single-word CPU accesses become whole-row bank transfers.
// Define SDRAM_ROW_CACHE_EN to keep the open row across accesses (write-back); otherwise every access goes to the bank (write-through).
module sdram_row_controller #(
    parameter int ROW_WORDS  = 512,
    parameter int WORD_IDX_W = 9,
    parameter int ROW_ADDR_W = 13
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            cpu_read,
    input  logic                            cpu_write,
    input  logic [ROW_ADDR_W+WORD_IDX_W-1:0] cpu_address,
    input  logic [31:0]                     cpu_writedata,
    output logic [31:0]                     cpu_readdata,
    output logic                            cpu_ack,
    input  logic                            bank_wait,
    output logic                            bank_write_enable,
    output logic [ROW_ADDR_W-1:0]           bank_column_addr,
    output logic [ROW_WORDS*32-1:0]         bank_row_wdata,
    input  logic [ROW_WORDS*32-1:0]         bank_row_rdata
);

`ifdef SDRAM_ROW_CACHE_EN
    localparam bit CACHE_EN = 1'b1;
`else
    localparam bit CACHE_EN = 1'b0;
`endif

    localparam int ROW_BITS = ROW_WORDS * 32;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        CAPTURE,
        WRITEBACK,
        ACK
    } state_t;

    state_t state;
    state_t state_next;

    logic                  request;
    logic [ROW_ADDR_W-1:0] cpu_row;
    logic [WORD_IDX_W-1:0] cpu_word;
    logic                  cache_hit;

    logic                  req_write;
    logic [ROW_ADDR_W-1:0] req_row;
    logic [WORD_IDX_W-1:0] req_word;
    logic [31:0]           req_data;

    logic [ROW_BITS-1:0]   row_buf;
    logic [ROW_ADDR_W-1:0] buf_tag;
    logic                  buf_valid;
    logic                  buf_dirty;
    logic [ROW_BITS-1:0]   captured_row;

    logic                  ack_d;
    logic                  we_d;
    logic [ROW_ADDR_W-1:0] col_d;

    assign request   = cpu_read | cpu_write;
    assign cpu_row   = cpu_address[WORD_IDX_W +: ROW_ADDR_W];
    assign cpu_word  = cpu_address[WORD_IDX_W-1:0];
    assign cache_hit = CACHE_EN && buf_valid && (buf_tag == cpu_row);

    // Row as it will sit in the buffer after CAPTURE: fetched row with a pending write merged in.
    always_comb begin
        captured_row = bank_row_rdata;
        if (req_write) begin
            captured_row[{req_word, 5'd0} +: 32] = req_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state             <= IDLE;
            cpu_ack           <= 1'b0;
            bank_write_enable <= 1'b0;
            bank_column_addr  <= '0;
        end else begin
            state             <= state_next;
            cpu_ack           <= ack_d;
            bank_write_enable <= we_d;
            bank_column_addr  <= col_d;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (request) begin
                    if (cache_hit) begin
                        state_next = ACK;
                    end else if (CACHE_EN && buf_valid && buf_dirty) begin
                        state_next = WRITEBACK;
                    end else begin
                        state_next = FETCH;
                    end
                end
            end
            FETCH: begin
                if (!bank_wait) begin
                    state_next = CAPTURE;
                end
            end
            CAPTURE: begin
                state_next = (!CACHE_EN && req_write) ? WRITEBACK : ACK;
            end
            WRITEBACK: begin
                if (!bank_wait) begin
                    state_next = CACHE_EN ? FETCH : ACK;
                end
            end
            ACK: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Bank-facing outputs are registered, so they are decoded from the state being entered.
    always_comb begin
        ack_d = (state_next == ACK);
        we_d  = (state_next == WRITEBACK);
        col_d = bank_column_addr;
        if (state_next == FETCH) begin
            col_d = (state == IDLE) ? cpu_row : req_row;
        end else if (state_next == WRITEBACK) begin
            col_d = (state == CAPTURE) ? req_row : buf_tag;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cpu_readdata   <= '0;
            bank_row_wdata <= '0;
            buf_valid      <= 1'b0;
            buf_dirty      <= 1'b0;
        end else begin
            if (state == IDLE && request) begin
                req_write <= cpu_write;
                req_row   <= cpu_row;
                req_word  <= cpu_word;
                req_data  <= cpu_writedata;
                if (cache_hit) begin
                    if (cpu_write) begin
                        row_buf[{cpu_word, 5'd0} +: 32] <= cpu_writedata;
                        buf_dirty                       <= 1'b1;
                    end else begin
                        cpu_readdata <= row_buf[{cpu_word, 5'd0} +: 32];
                    end
                end
            end

            if (state == CAPTURE) begin
                row_buf   <= captured_row;
                buf_tag   <= req_row;
                buf_valid <= 1'b1;
                buf_dirty <= req_write;
                if (!req_write) begin
                    cpu_readdata <= bank_row_rdata[{req_word, 5'd0} +: 32];
                end
            end

            if (state == WRITEBACK && !bank_wait) begin
                buf_dirty <= 1'b0;
            end

            if (!CACHE_EN && state == ACK) begin
                buf_valid <= 1'b0;
            end

            if (state_next == WRITEBACK && state != WRITEBACK) begin
                bank_row_wdata <= (state == CAPTURE) ? captured_row : row_buf;
            end
        end
    end

endmodule

// File: tb/tb_sdram_row_controller.sv
// Self-checking bench for sdram_row_controller: behavioural bank model, table vectors, corner sequences and random accesses.
module tb_sdram_row_controller;

`ifdef SDRAM_ROW_CACHE_EN
    localparam bit CACHE_EN = 1'b1;
`else
    localparam bit CACHE_EN = 1'b0;
`endif

    localparam int ROW_WORDS  = 512;
    localparam int WORD_IDX_W = 9;
    localparam int ROW_ADDR_W = 13;
    localparam int RB         = ROW_WORDS * 32;

    logic                            clock;
    logic                            reset;
    logic                            cpu_read;
    logic                            cpu_write;
    logic [ROW_ADDR_W+WORD_IDX_W-1:0] cpu_address;
    logic [31:0]                     cpu_writedata;
    logic [31:0]                     cpu_readdata;
    logic                            cpu_ack;
    logic                            bank_wait;
    logic                            bank_write_enable;
    logic [ROW_ADDR_W-1:0]           bank_column_addr;
    logic [RB-1:0]                   bank_row_wdata;
    logic [RB-1:0]                   bank_row_rdata;

    sdram_row_controller #(
        .ROW_WORDS (ROW_WORDS),
        .WORD_IDX_W(WORD_IDX_W),
        .ROW_ADDR_W(ROW_ADDR_W)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .cpu_read         (cpu_read),
        .cpu_write        (cpu_write),
        .cpu_address      (cpu_address),
        .cpu_writedata    (cpu_writedata),
        .cpu_readdata     (cpu_readdata),
        .cpu_ack          (cpu_ack),
        .bank_wait        (bank_wait),
        .bank_write_enable(bank_write_enable),
        .bank_column_addr (bank_column_addr),
        .bank_row_wdata   (bank_row_wdata),
        .bank_row_rdata   (bank_row_rdata)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    // Bank: unwritten words hold a fixed address-derived pattern; reads registered, nothing moves while busy.
    function automatic logic [31:0] pattern(input int unsigned a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
    endfunction

    logic [RB-1:0] bank_mem [int];

    function automatic logic [RB-1:0] bank_row(input int r);
        logic [RB-1:0] v;
        if (bank_mem.exists(r)) return bank_mem[r];
        for (int unsigned w = 0; w < ROW_WORDS; w++) begin
            v[w*32 +: 32] = pattern(r * ROW_WORDS + w);
        end
        return v;
    endfunction

    always @(posedge clock) begin
        if (!bank_wait) begin
            if (bank_write_enable) begin
                bank_mem[int'(bank_column_addr)] = bank_row_wdata;
            end else begin
                bank_row_rdata <= bank_row(int'(bank_column_addr));
            end
        end
    end

    // Reference model: expected bank words plus (cached build) open row tag and words written since fetch.
    logic [31:0] exp_bank [int];
    logic [31:0] m_dirty_words [int];
    bit          m_valid;
    int          m_tag;
    logic [31:0] m_last_rd;

    function automatic logic [31:0] exp_word(input int a);
        return exp_bank.exists(a) ? exp_bank[a] : pattern(a);
    endfunction

    task automatic model_reset();
        m_valid   = 1'b0;
        m_tag     = 0;
        m_last_rd = '0;
        m_dirty_words.delete();
    endtask

    task automatic model_access(input bit wr, input int addr, input logic [31:0] data,
                                input int unsigned w_cycles, output int lat, output logic [31:0] rd);
        int row;
        int w;
        row = addr / ROW_WORDS;
        w   = addr % ROW_WORDS;
        if (CACHE_EN) begin
            if (m_valid && m_tag == row) begin
                lat = 1;
            end else begin
                lat = 3 + int'(w_cycles);
                if (m_valid && m_dirty_words.size() > 0) begin
                    foreach (m_dirty_words[k]) exp_bank[m_tag * ROW_WORDS + k] = m_dirty_words[k];
                    lat = lat + 1;
                end
                m_dirty_words.delete();
                m_valid = 1'b1;
                m_tag   = row;
            end
            if (wr) m_dirty_words[w] = data;
            else    m_last_rd = m_dirty_words.exists(w) ? m_dirty_words[w] : exp_word(addr);
        end else begin
            if (wr) begin
                exp_bank[addr] = data;
                lat = 4 + int'(w_cycles);
            end else begin
                m_last_rd = exp_word(addr);
                lat = 3 + int'(w_cycles);
            end
        end
        rd = m_last_rd;
    endtask

    // One access: bank_wait high for the first w_cycles cycles after acceptance; request and
    // address are disturbed after acceptance to show they are latched.
    task automatic do_txn(input bit wr, input logic [21:0] addr, input logic [31:0] data,
                          input int unsigned w_cycles, output int lat, output logic [31:0] rd,
                          output bit col_ok, output bit ack_after);
        @(negedge clock);
        cpu_write     = wr;
        cpu_read      = !wr;
        cpu_address   = addr;
        cpu_writedata = data;
        bank_wait     = 1'b0;
        @(posedge clock);
        lat    = -1;
        col_ok = 1'b1;
        for (int unsigned c = 1; c <= 400; c++) begin
            #1;
            bank_wait = (c <= w_cycles);
            if (cpu_ack) begin
                lat = int'(c);
                break;
            end
            if (c == 1) begin
                cpu_address   = 22'($urandom);
                cpu_writedata = $urandom;
                if ($urandom_range(0, 1) == 1) begin
                    cpu_read  = 1'b0;
                    cpu_write = 1'b0;
                end
            end
            if (c <= w_cycles && !bank_write_enable && bank_column_addr != addr[21:9]) col_ok = 1'b0;
            @(posedge clock);
        end
        rd        = cpu_readdata;
        cpu_read  = 1'b0;
        cpu_write = 1'b0;
        bank_wait = 1'b0;
        @(posedge clock);
        #1;
        ack_after = cpu_ack;
    endtask

    task automatic run_check(input string tag, input bit wr, input int unsigned addr,
                             input logic [31:0] data, input int unsigned w_cycles);
        int          exp_lat;
        logic [31:0] exp_rd;
        int          lat;
        logic [31:0] rd;
        bit          col_ok;
        bit          ack_after;
        model_access(wr, int'(addr), data, w_cycles, exp_lat, exp_rd);
        do_txn(wr, 22'(addr), data, w_cycles, lat, rd, col_ok, ack_after);
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_rdata"}, rd, exp_rd);
        check({tag, "_ack_width"}, ack_after, 0);
        if (w_cycles > 0 && exp_lat > 1) check({tag, "_col_stable"}, col_ok, 1);
    endtask

    typedef struct {
        bit          wr;
        int unsigned addr;
        logic [31:0] data;
        int          lat;
        logic [31:0] rdata;
    } vec_t;

    vec_t vecs [5];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [RB-1:0] row_v;
        int            lat;
        logic [31:0]   rd;
        int            dummy_lat;
        logic [31:0]   dummy_rd;
        bit            col_ok;
        bit            ack_after;
        int unsigned   rows [5];
        int unsigned   row;
        int unsigned   word;
        bit            wr;
        int unsigned   wc;
        int unsigned   wb_cycle;
        int unsigned   bad;

        vecs[0] = '{wr: 1'b0, addr: (5 << 9) | 3, data: 32'h0, lat: 3, rdata: 32'hDEAD_BEEF};
        vecs[1] = '{wr: 1'b1, addr: (5 << 9) | 3, data: 32'h1234_5678, lat: CACHE_EN ? 1 : 4, rdata: 32'hDEAD_BEEF};
        vecs[2] = '{wr: 1'b0, addr: (5 << 9) | 3, data: 32'h0, lat: CACHE_EN ? 1 : 3, rdata: 32'h1234_5678};
        vecs[3] = '{wr: 1'b0, addr: (6 << 9), data: 32'h0, lat: CACHE_EN ? 4 : 3, rdata: pattern(6 << 9)};
        vecs[4] = '{wr: 1'b0, addr: 22'h3F_FFFF, data: 32'h0, lat: 3, rdata: pattern(22'h3F_FFFF)};
        rows = '{5, 6, 7, 9, 8191};

        row_v = bank_row(5);
        row_v[3*32 +: 32] = 32'hDEAD_BEEF;
        bank_mem[5] = row_v;
        exp_bank[(5 << 9) | 3] = 32'hDEAD_BEEF;
        model_reset();

        reset         = 1'b1;
        cpu_read      = 1'b1;
        cpu_write     = 1'b1;
        cpu_address   = (5 << 9) | 3;
        cpu_writedata = 32'hFFFF_FFFF;
        bank_wait     = 1'b0;
        for (int unsigned i = 0; i < 2; i++) begin
            @(posedge clock);
            #1;
            check($sformatf("reset%0d_ack", i), cpu_ack, 0);
            check($sformatf("reset%0d_we", i), bank_write_enable, 0);
        end
        check("reset_readdata", cpu_readdata, 0);
        check("reset_col", bank_column_addr, 0);
        check("reset_wdata_nonzero", |bank_row_wdata, 0);
        @(negedge clock);
        cpu_read  = 1'b0;
        cpu_write = 1'b0;
        reset     = 1'b0;

        for (int unsigned i = 0; i < 5; i++) begin
            model_access(vecs[i].wr, int'(vecs[i].addr), vecs[i].data, 0, dummy_lat, dummy_rd);
            do_txn(vecs[i].wr, 22'(vecs[i].addr), vecs[i].data, 0, lat, rd, col_ok, ack_after);
            check($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
            check($sformatf("vec%0d_rdata", i), rd, vecs[i].rdata);
            check($sformatf("vec%0d_ack_width", i), ack_after, 0);
        end
        row_v = bank_row(5);
        check("bank_row5_word3", row_v[3*32 +: 32], 32'h1234_5678);

        run_check("wait66", 1'b0, (7 << 9) | 100, 32'h0, 66);

        if (CACHE_EN) begin
            run_check("dirty_r9", 1'b1, (9 << 9) | 17, 32'hCAFE_F00D, 0);
            wb_cycle = 1;
            @(negedge clock);
            cpu_read    = 1'b1;
            cpu_write   = 1'b0;
            cpu_address = (10 << 9) | 1;
        end else begin
            wb_cycle = 3;
            @(negedge clock);
            cpu_read      = 1'b0;
            cpu_write     = 1'b1;
            cpu_address   = (9 << 9) | 17;
            cpu_writedata = 32'hCAFE_F00D;
        end
        @(posedge clock);
        for (int unsigned c = 1; c < wb_cycle; c++) @(posedge clock);
        #1;
        check("abort_in_writeback", bank_write_enable, 1);
        bank_wait = 1'b1;
        reset     = 1'b1;
        cpu_read  = 1'b0;
        cpu_write = 1'b0;
        @(posedge clock);
        #1;
        check("abort_we_cleared", bank_write_enable, 0);
        check("abort_no_ack", cpu_ack, 0);
        reset     = 1'b0;
        bank_wait = 1'b0;
        model_reset();
        run_check("after_abort", 1'b0, (9 << 9) | 17, 32'h0, 0);

        for (int unsigned i = 0; i < 40; i++) begin
            row = rows[$urandom_range(0, 4)];
            case ($urandom_range(0, 3))
                0:       word = 0;
                1:       word = 511;
                default: word = $urandom_range(0, 511);
            endcase
            wr = 1'($urandom_range(0, 1));
            wc = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : 0;
            run_check($sformatf("rnd%0d", i), wr, row * ROW_WORDS + word, $urandom, wc);
        end

        bad = 0;
        foreach (exp_bank[a]) begin
            row_v = bank_row(a / ROW_WORDS);
            if (row_v[(a % ROW_WORDS)*32 +: 32] !== exp_bank[a]) bad++;
        end
        check("bank_contents_bad_words", bad, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
